// File: rtl/apb_node_reg_if.sv
// Bus bundle for apb_node_reg: upstream APB slave side and shared/one-hot downstream side.
// The slave modport is the node's view; the master modport is the surrounding bridge/peripheral view.
interface apb_node_reg_if #(
    parameter int NB_MASTER      = 9,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0]           paddr_i;
    logic [APB_DATA_WIDTH-1:0]           pwdata_i;
    logic                                pwrite_i;
    logic                                psel_i;
    logic                                penable_i;
    logic [APB_DATA_WIDTH-1:0]           prdata_o;
    logic                                pready_o;
    logic                                pslverr_o;
    logic [APB_ADDR_WIDTH-1:0]           paddr_o;
    logic [APB_DATA_WIDTH-1:0]           pwdata_o;
    logic                                pwrite_o;
    logic [NB_MASTER-1:0]                psel_o;
    logic                                penable_o;
    logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i;
    logic [NB_MASTER-1:0]                pready_i;
    logic [NB_MASTER-1:0]                pslverr_i;

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_i, pready_i, pslverr_i,
        output prdata_o, pready_o, pslverr_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_i, pready_i, pslverr_i,
        input  prdata_o, pready_o, pslverr_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );
endinterface

// File: rtl/apb_node_reg.sv
// Registered APB 1-to-N node with per-port address ranges and decode-miss error response.
// Optional downstream access timeout enabled by defining APB_NODE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an upstream setup phase; decode and latch on setup
// DSETUP  | downstream setup phase on the selected port
// DACCESS | downstream access phase, waiting for the selected port's ready
// RESP    | one-cycle upstream response with captured data/error
module apb_node_reg #(
    parameter int NB_MASTER      = 9,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    apb_node_reg_if.slave                       bus,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i
);
    localparam int SW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

    typedef enum logic [1:0] {IDLE, DSETUP, DACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic [SW-1:0]             sel_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;

    logic                      setup;
    logic                      hit_any;
    logic [SW-1:0]             hit_idx;
    logic                      tmo_expired;

    assign setup = bus.psel_i && !bus.penable_i;

    // Descending scan so the lowest matching port index ends up selected.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NB_MASTER - 1; k >= 0; k--) begin
            if (bus.paddr_i >= start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                bus.paddr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit_any = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

`ifdef APB_NODE_TIMEOUT_EN
    // Down-counter: loaded in DSETUP, expires when it reaches zero in DACCESS.
    logic [15:0] tmo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (state_q == DSETUP) begin
            tmo_q <= 16'(TIMEOUT_CYCLES);
        end else if (state_q == DACCESS && tmo_q != '0) begin
            tmo_q <= tmo_q - 16'd1;
        end
    end

    assign tmo_expired = (state_q == DACCESS) && (tmo_q == '0);
`else
    logic unused_tmo;
    assign unused_tmo  = |16'(TIMEOUT_CYCLES);
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.psel_o    = '0;
        bus.penable_o = 1'b0;
        bus.pready_o  = 1'b0;
        bus.pslverr_o = 1'b0;
        bus.prdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (setup) state_d = hit_any ? DSETUP : RESP;
            end
            DSETUP: begin
                bus.psel_o[sel_q] = 1'b1;
                state_d           = DACCESS;
            end
            DACCESS: begin
                bus.psel_o[sel_q] = 1'b1;
                bus.penable_o     = 1'b1;
                if (bus.pready_i[sel_q] || tmo_expired) state_d = RESP;
            end
            RESP: begin
                bus.pready_o  = 1'b1;
                bus.pslverr_o = err_q;
                bus.prdata_o  = rdata_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == IDLE && setup) begin
            addr_q  <= bus.paddr_i;
            wdata_q <= bus.pwdata_i;
            write_q <= bus.pwrite_i;
            sel_q   <= hit_idx;
            rdata_q <= '0;
            err_q   <= !hit_any;
        end else if (state_q == DACCESS) begin
            // A ready in the expiry cycle still completes normally.
            if (bus.pready_i[sel_q]) begin
                rdata_q <= write_q ? '0 : bus.prdata_i[int'(sel_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                err_q   <= bus.pslverr_i[sel_q];
            end else if (tmo_expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.paddr_o  = addr_q;
    assign bus.pwdata_o = wdata_q;
    assign bus.pwrite_o = write_q;
endmodule

// File: tb/tb_apb_node_reg.sv
// Directed self-checking bench for apb_node_reg with a configurable wait-state/data/error responder.
// Define APB_NODE_TIMEOUT_EN to also exercise the access timeout path.
module tb_apb_node_reg;
    localparam int NB = 9;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_i;
    logic rst_i;
    logic [NB*AW-1:0] start_addr;
    logic [NB*AW-1:0] end_addr;

    apb_node_reg_if #(.NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb_node_reg #(
        .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
        .start_addr_i(start_addr), .end_addr_i(end_addr)
    );

    int          wait_cfg [NB];
    logic [31:0] data_cfg [NB];
    logic [NB-1:0] err_cfg;
    int          acc_cnt;
    int          cyc;
    int          n_cmp;
    int          n_err;

    // Transaction results
    int          r_lat;
    logic [31:0] r_data;
    logic        r_err;
    logic [NB-1:0] r_sel;
    logic [NB-1:0] r_sel_resp;
    logic        r_pen_first;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic        r_done;
    int          r_rdy_cyc;
    int          r_sel_cyc;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) acc_cnt <= 0;
        else if ((|bus.psel_o) && bus.penable_o && !(|(bus.pready_i & bus.psel_o))) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        bus.prdata_i  = '0;
        bus.pready_i  = '0;
        bus.pslverr_i = err_cfg;
        for (int k = 0; k < NB; k++) begin
            bus.prdata_i[k*DW +: DW] = data_cfg[k];
            bus.pready_i[k] = bus.psel_o[k] && bus.penable_o && (acc_cnt >= wait_cfg[k]);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
        @(negedge clk_i);
        bus.paddr_i   = addr;
        bus.pwdata_i  = wdata;
        bus.pwrite_i  = wr;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        r_lat = 0; r_data = '0; r_err = 1'b0; r_sel = '0; r_sel_resp = '0;
        r_pen_first = 1'b0; r_paddr = '0; r_pwdata = '0; r_pwrite = 1'b0;
        r_done = 1'b0; r_rdy_cyc = 0; r_sel_cyc = 0;
        for (int i = 1; i <= 40 && !r_done; i++) begin
            @(negedge clk_i);
            bus.penable_i = 1'b1;
            if ((|bus.psel_o) && r_sel == '0) begin
                r_sel_cyc   = cyc;
                r_pen_first = bus.penable_o;
                r_paddr     = bus.paddr_o;
                r_pwdata    = bus.pwdata_o;
                r_pwrite    = bus.pwrite_o;
            end
            r_sel = r_sel | bus.psel_o;
            if (bus.pready_o) begin
                r_done     = 1'b1;
                r_lat      = i;
                r_data     = bus.prdata_o;
                r_err      = bus.pslverr_o;
                r_sel_resp = bus.psel_o;
                r_rdy_cyc  = cyc;
            end
        end
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input int lat, input logic [NB-1:0] sel,
                              input logic [31:0] data, input logic err);
        check_val({tag, "_done"}, 64'(r_done), 64'd1);
        check_val({tag, "_lat"}, 64'(r_lat), 64'(lat));
        check_val({tag, "_sel"}, 64'(r_sel), 64'(sel));
        check_val({tag, "_data"}, 64'(r_data), 64'(data));
        check_val({tag, "_err"}, 64'(r_err), 64'(err));
        check_val({tag, "_sel_resp"}, 64'(r_sel_resp), 64'd0);
    endtask

    initial begin
        logic seen_sel, seen_rdy;
        n_cmp = 0; n_err = 0; cyc = 0;
        rst_i = 1'b1;
        bus.paddr_i = '0; bus.pwdata_i = '0; bus.pwrite_i = 1'b0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        err_cfg = '0;
        for (int k = 0; k < NB; k++) begin
            wait_cfg[k] = 0;
            data_cfg[k] = 32'hC0DE_0000 + 32'(k);
            start_addr[k*AW +: AW] = 32'h1A10_0000 + 32'(k) * 32'h1000;
            end_addr[k*AW +: AW]   = 32'h1A10_0FFF + 32'(k) * 32'h1000;
        end
        data_cfg[0] = 32'hDEAD_BEEF;
        data_cfg[7] = 32'h7777_7777;
        wait_cfg[7] = 2;

        repeat (2) @(negedge clk_i);
        check_val("rst_pready", 64'(bus.pready_o), 64'd0);
        check_val("rst_psel", 64'(bus.psel_o), 64'd0);
        check_val("rst_paddr", 64'(bus.paddr_o), 64'd0);
        check_val("rst_prdata", 64'(bus.prdata_o), 64'd0);
        rst_i = 1'b0;

        xfer(32'h1A10_0004, 32'h0, 1'b0);
        check_xfer("rd_p0", 3, 9'h001, 32'hDEAD_BEEF, 1'b0);
        check_val("rd_p0_pen_setup", 64'(r_pen_first), 64'd0);

        xfer(32'h1A10_7000, 32'h0000_55AA, 1'b1);
        check_xfer("wr_p7", 5, 9'h080, 32'h0, 1'b0);
        check_val("wr_p7_pwdata", 64'(r_pwdata), 64'h55AA);
        check_val("wr_p7_pwrite", 64'(r_pwrite), 64'd1);
        check_val("wr_p7_paddr", 64'(r_paddr), 64'h1A10_7000);

        xfer(32'h0000_0010, 32'h0, 1'b0);
        check_xfer("miss", 1, 9'h000, 32'h0, 1'b1);

        start_addr[5*AW +: AW] = 32'h1A10_2000;
        end_addr[5*AW +: AW]   = 32'h1A10_5FFF;
        err_cfg[2] = 1'b1;
        xfer(32'h1A10_2000, 32'h0, 1'b0);
        check_xfer("overlap", 3, 9'h004, 32'hC0DE_0002, 1'b1);
        err_cfg[2] = 1'b0;

        xfer(32'h1A10_8FFF, 32'h0, 1'b0);
        check_xfer("end_p8", 3, 9'h100, 32'hC0DE_0008, 1'b0);
        xfer(32'h1A10_9000, 32'h0, 1'b0);
        check_xfer("past_end", 1, 9'h000, 32'h0, 1'b1);

        xfer(32'h1A10_1008, 32'h0, 1'b0);
        begin
            int first_rdy;
            first_rdy = r_rdy_cyc;
            check_val("b2b_first_data", 64'(r_data), 64'hC0DE_0001);
            xfer(32'h1A10_4000, 32'h0, 1'b0);
            check_val("b2b_gap", 64'(r_sel_cyc - first_rdy), 64'd2);
            check_xfer("b2b_second", 3, 9'h010, 32'hC0DE_0004, 1'b0);
        end

        // psel with penable already high in IDLE must be ignored
        @(negedge clk_i);
        bus.paddr_i = 32'h1A10_0000; bus.psel_i = 1'b1; bus.penable_i = 1'b1;
        seen_sel = 1'b0; seen_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            seen_sel = seen_sel | (|bus.psel_o);
            seen_rdy = seen_rdy | bus.pready_o;
        end
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        check_val("viol_psel", 64'(seen_sel), 64'd0);
        check_val("viol_pready", 64'(seen_rdy), 64'd0);

        wait_cfg[6] = 4;
        xfer(32'h1A10_6010, 32'h0, 1'b0);
        check_xfer("ready_at_limit", 7, 9'h040, 32'hC0DE_0006, 1'b0);
`ifdef APB_NODE_TIMEOUT_EN
        wait_cfg[6] = 1000;
        xfer(32'h1A10_6010, 32'h0, 1'b0);
        check_xfer("timeout", 7, 9'h040, 32'h0, 1'b1);
`else
        wait_cfg[6] = 10;
        xfer(32'h1A10_6010, 32'h0, 1'b0);
        check_xfer("long_wait", 13, 9'h040, 32'hC0DE_0006, 1'b0);
`endif

        // Reset during DACCESS
        wait_cfg[3] = 50;
        @(negedge clk_i);
        bus.paddr_i = 32'h1A10_3010; bus.pwrite_i = 1'b0; bus.psel_i = 1'b1; bus.penable_i = 1'b0;
        @(negedge clk_i);
        bus.penable_i = 1'b1;
        @(negedge clk_i);
        check_val("mid_psel", 64'(bus.psel_o), 64'h008);
        check_val("mid_penable", 64'(bus.penable_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check_val("arst_psel", 64'(bus.psel_o), 64'd0);
        check_val("arst_penable", 64'(bus.penable_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        seen_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            seen_rdy = seen_rdy | bus.pready_o;
        end
        check_val("arst_no_pready", 64'(seen_rdy), 64'd0);
        check_val("arst_paddr", 64'(bus.paddr_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_node_reg.md
Name: apb_node_reg

Overview:
- Parametrised, registered APB 1-to-N node: one upstream APB slave port fans out to NB_MASTER downstream APB master ports.
- Decoding uses per-port start/end address ranges.
- Adds decode-miss error response and per-transaction state tracking.
- Sits between the core-side APB bridge and the peripheral set (UART, GPIO, SPI, timer, ...); it succeeds the fixed-count combinational node with registered, error-aware routing.

Parameters:
NB_MASTER, 9, number of downstream ports (1..32)
APB_ADDR_WIDTH, 32, address width
APB_DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 255, max downstream ACCESS cycles before abort (used only with optional feature; 1..65535)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
paddr_i  in  APB_ADDR_WIDTH  upstream address
pwdata_i  in  APB_DATA_WIDTH  upstream write data
pwrite_i  in  1  upstream write
psel_i  in  1  upstream select
penable_i  in  1  upstream enable
prdata_o  out  APB_DATA_WIDTH  upstream read data
pready_o  out  1  upstream ready
pslverr_o  out  1  upstream error
paddr_o  out  APB_ADDR_WIDTH  downstream address (shared)
pwdata_o  out  APB_DATA_WIDTH  downstream write data (shared)
pwrite_o  out  1  downstream write (shared)
psel_o  out  NB_MASTER  downstream one-hot select
penable_o  out  1  downstream enable (shared)
prdata_i  in  NB_MASTER*APB_DATA_WIDTH  downstream read data, port k at slice k
pready_i  in  NB_MASTER  downstream ready
pslverr_i  in  NB_MASTER  downstream error
start_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  inclusive range start per port
end_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  inclusive range end per port

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; latched address/data/select registers 0.
- FSM states: IDLE, DSETUP, DACCESS, RESP.
- IDLE:
  - On psel_i=1, penable_i=0: latch paddr_i, pwdata_i, pwrite_i.
  - Decode: hit[k] = start_k <= paddr_i <= end_k (unsigned). The lowest index hit wins on overlap.
  - Any hit -> DSETUP. No hit -> RESP with error flag.
- DSETUP:
  - psel_o[sel]=1, penable_o=0, paddr_o/pwdata_o/pwrite_o driven from the latched values.
  - Unconditionally -> DACCESS.
- DACCESS:
  - psel_o[sel]=1, penable_o=1.
  - On pready_i[sel]=1: capture prdata slice sel (reads only; writes capture 0) and pslverr_i[sel] -> RESP.
- RESP:
  - pready_o=1 for exactly one cycle, prdata_o=captured data, pslverr_o=captured error.
  - All psel_o=0. Then -> IDLE.
- Outside RESP: pready_o=0, pslverr_o=0, prdata_o=0.
- Outside DSETUP/DACCESS: psel_o=0, penable_o=0. The shared paddr_o/pwdata_o/pwrite_o keep their last latched value.
- Latency, hit: upstream setup in cycle T; pready_o high at T+3 if downstream has zero wait states. Each downstream wait state adds one cycle.
- Latency, miss: pready_o=1, pslverr_o=1, prdata_o=0 at T+1. No downstream psel asserted.
- Protocol rules:
  - Upstream holds psel_i/penable_i/addr/data until pready_o. The node ignores upstream changes outside IDLE.
  - A new setup is accepted in the IDLE cycle immediately after RESP (back-to-back).
  - psel_i=1 with penable_i=1 seen in IDLE (protocol violation) is ignored.
- Address ranges are sampled only in IDLE; changes mid-transaction have no effect.
- Reset mid-transaction: all selects drop asynchronously, FSM -> IDLE; no response is issued.

Optional Feature:
Macro APB_NODE_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on DSETUP entry, incremented each DACCESS cycle without pready_i[sel].
  - When the count reaches TIMEOUT_CYCLES, the node abandons the transfer: psel_o/penable_o drop next cycle, -> RESP with pslverr_o=1, prdata_o=0.
  - A pready_i arriving in the same cycle as the limit wins (normal completion).
- Not defined: no counter; DACCESS waits indefinitely.

Test Plan:
- Hit port 0, range 0x1A100000-0x1A100FFF. Read 0x1A100004; port 0 returns 0xDEADBEEF with zero waits -> psel_o=9'b000000001, pready_o at T+3, prdata_o=0xDEADBEEF, pslverr_o=0.
- Write 0x1A107000 (port 7 range), data 0x55AA; port 7 inserts 2 waits -> pwdata_o=0x55AA, pwrite_o=1, pready_o at T+5, prdata_o=0.
- Miss: read 0x00000010 -> pready_o=1, pslverr_o=1 at T+1; psel_o stays 0 throughout.
- Overlap: ports 2 and 5 both cover 0x1A102000. Access that address -> only psel_o[2] asserted. Downstream pslverr_i[2]=1 -> pslverr_o=1.
- Back-to-back: two reads issued the cycle after each RESP -> second psel_o asserts 2 cycles after first pready_o. Reset asserted in DACCESS -> psel_o=0, penable_o=0 immediately, no pready_o.
- With APB_NODE_TIMEOUT_EN, TIMEOUT_CYCLES=4, port never ready -> pslverr_o=1 and pready_o=1 at T+7; psel_o deasserted before RESP.
